// File: rtl/univ_shift_reg.sv
// Universal register: parallel load, shift/rotate in both directions, and a synchronous clear.
// A frame counter pulses frame_done once WIDTH shift/rotate operations have been applied in a row.
module univ_shift_reg #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             serial_in_r,
    input  logic             serial_in_l,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out_r,
    output logic             serial_out_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_SHL   = 3'b011,
        MODE_ROR   = 3'b100,
        MODE_ROL   = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_RSVD  = 3'b111
    } mode_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] data_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             done_nxt;
    logic             is_shift;
    logic             is_restart;

    always_comb begin
        data_nxt   = data_out;
        is_shift   = 1'b0;
        is_restart = 1'b0;
        case (mode_t'(mode))
            MODE_LOAD: begin
                data_nxt   = data_in;
                is_restart = 1'b1;
            end
            MODE_SHR: begin
                data_nxt = {serial_in_r, data_out[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            MODE_SHL: begin
                data_nxt = {data_out[WIDTH-2:0], serial_in_l};
                is_shift = 1'b1;
            end
            MODE_ROR: begin
                data_nxt = {data_out[0], data_out[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            MODE_ROL: begin
                data_nxt = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
                is_shift = 1'b1;
            end
            MODE_CLEAR: begin
                data_nxt   = '0;
                is_restart = 1'b1;
            end
            default: data_nxt = data_out;
        endcase
    end

    // Wrap at WIDTH-1 explicitly so non-power-of-2 widths never show WIDTH or above.
    always_comb begin
        cnt_nxt  = shift_cnt;
        done_nxt = 1'b0;
        if (is_restart) begin
            cnt_nxt = '0;
        end else if (is_shift) begin
            if (shift_cnt == CNT_LAST) begin
                cnt_nxt  = '0;
                done_nxt = 1'b1;
            end else begin
                cnt_nxt = shift_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out   <= '0;
            shift_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            data_out   <= data_nxt;
            shift_cnt  <= cnt_nxt;
            frame_done <= done_nxt;
        end
    end

    assign serial_out_r = data_out[0];
    assign serial_out_l = data_out[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: an 8-bit instance driven from a vector table plus
// hand sequences, and a 5-bit instance for the non-power-of-2 frame wrap.
module tb_univ_shift_reg;

    localparam int W8 = 8;
    localparam int W5 = 5;

    logic          clk;
    logic          reset_n;

    logic [2:0]    mode8;
    logic [W8-1:0] din8;
    logic          sr8, sl8;
    logic [W8-1:0] dout8;
    logic          sor8, sol8;
    logic [2:0]    cnt8;
    logic          done8;

    logic [2:0]    mode5;
    logic [W5-1:0] din5;
    logic          sr5, sl5;
    logic [W5-1:0] dout5;
    logic          sor5, sol5;
    logic [2:0]    cnt5;
    logic          done5;

    int n_checks;
    int n_pass;

    typedef struct {
        logic [2:0]    mode;
        logic [W8-1:0] din;
        logic          sr;
        logic          sl;
        logic [W8-1:0] ed;
        logic [2:0]    ec;
        logic          edone;
    } vec_t;

    vec_t vecs_a[$];
    vec_t vecs_b[$];

    univ_shift_reg #(.WIDTH(W8)) dut8 (
        .clk          (clk),
        .reset_n      (reset_n),
        .mode         (mode8),
        .data_in      (din8),
        .serial_in_r  (sr8),
        .serial_in_l  (sl8),
        .data_out     (dout8),
        .serial_out_r (sor8),
        .serial_out_l (sol8),
        .shift_cnt    (cnt8),
        .frame_done   (done8)
    );

    univ_shift_reg #(.WIDTH(W5)) dut5 (
        .clk          (clk),
        .reset_n      (reset_n),
        .mode         (mode5),
        .data_in      (din5),
        .serial_in_r  (sr5),
        .serial_in_l  (sl5),
        .data_out     (dout5),
        .serial_out_r (sor5),
        .serial_out_l (sol5),
        .shift_cnt    (cnt5),
        .frame_done   (done5)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // drivers: inputs change on the falling edge, outputs sampled 1ns after the rising edge
    task automatic drive8(input logic [2:0] m, input logic [W8-1:0] d, input logic r, input logic l);
        @(negedge clk);
        mode8 = m;
        din8  = d;
        sr8   = r;
        sl8   = l;
        @(posedge clk);
        #1;
    endtask

    task automatic drive5(input logic [2:0] m, input logic r);
        @(negedge clk);
        mode5 = m;
        sr5   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [W8-1:0] ed, input logic [2:0] ec,
                          input logic edone);
        check({tag, ".data"}, 64'(dout8), 64'(ed));
        check({tag, ".cnt"}, 64'(cnt8), 64'(ec));
        check({tag, ".done"}, 64'(done8), 64'(edone));
        check({tag, ".sor"}, 64'(sor8), 64'(ed[0]));
        check({tag, ".sol"}, 64'(sol8), 64'(ed[W8-1]));
    endtask

    task automatic add(inout vec_t q[$], input logic [2:0] m, input logic [W8-1:0] d,
                       input logic r, input logic l, input logic [W8-1:0] ed,
                       input logic [2:0] ec, input logic edone);
        vec_t v;
        v.mode = m; v.din = d; v.sr = r; v.sl = l;
        v.ed = ed; v.ec = ec; v.edone = edone;
        q.push_back(v);
    endtask

    task automatic run_table(input vec_t q[$], input string tag);
        foreach (q[i]) begin
            drive8(q[i].mode, q[i].din, q[i].sr, q[i].sl);
            check8($sformatf("%s[%0d]", tag, i), q[i].ed, q[i].ec, q[i].edone);
        end
    endtask

    initial begin
        logic [W8-1:0] exp8;
        logic [W5-1:0] exp5;
        int            c;

        n_checks = 0;
        n_pass   = 0;

        // hold/load, reserved mode, rotates, clear and an 8-bit SHR frame
        add(vecs_a, 3'b001, 8'hA5, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b0);
        add(vecs_a, 3'b000, 8'h00, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b0);
        add(vecs_a, 3'b000, 8'h00, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b0);
        add(vecs_a, 3'b000, 8'h00, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b0);
        add(vecs_a, 3'b111, 8'h3C, 1'b1, 1'b1, 8'hA5, 3'd0, 1'b0);
        add(vecs_a, 3'b001, 8'h81, 1'b0, 1'b0, 8'h81, 3'd0, 1'b0);
        add(vecs_a, 3'b101, 8'h00, 1'b0, 1'b0, 8'h03, 3'd1, 1'b0);
        add(vecs_a, 3'b100, 8'h00, 1'b0, 1'b0, 8'h81, 3'd2, 1'b0);
        add(vecs_a, 3'b100, 8'h00, 1'b0, 1'b0, 8'hC0, 3'd3, 1'b0);
        add(vecs_a, 3'b111, 8'h00, 1'b0, 1'b0, 8'hC0, 3'd3, 1'b0);
        add(vecs_a, 3'b110, 8'hFF, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
        add(vecs_a, 3'b010, 8'h00, 1'b1, 1'b0, 8'h80, 3'd1, 1'b0);
        add(vecs_a, 3'b010, 8'h00, 1'b0, 1'b0, 8'h40, 3'd2, 1'b0);
        add(vecs_a, 3'b010, 8'h00, 1'b1, 1'b0, 8'hA0, 3'd3, 1'b0);
        add(vecs_a, 3'b010, 8'h00, 1'b1, 1'b0, 8'hD0, 3'd4, 1'b0);
        add(vecs_a, 3'b010, 8'h00, 1'b0, 1'b0, 8'h68, 3'd5, 1'b0);
        add(vecs_a, 3'b010, 8'h00, 1'b0, 1'b0, 8'h34, 3'd6, 1'b0);
        add(vecs_a, 3'b010, 8'h00, 1'b1, 1'b0, 8'h9A, 3'd7, 1'b0);
        add(vecs_a, 3'b010, 8'h00, 1'b0, 1'b0, 8'h4D, 3'd0, 1'b1);
        add(vecs_a, 3'b000, 8'h00, 1'b0, 1'b0, 8'h4D, 3'd0, 1'b0);

        // mixed directions up to count 7, then LOAD instead of the 8th shift
        add(vecs_b, 3'b010, 8'h00, 1'b0, 1'b0, 8'h7F, 3'd1, 1'b0);
        add(vecs_b, 3'b011, 8'h00, 1'b0, 1'b0, 8'hFE, 3'd2, 1'b0);
        add(vecs_b, 3'b100, 8'h00, 1'b0, 1'b0, 8'h7F, 3'd3, 1'b0);
        add(vecs_b, 3'b101, 8'h00, 1'b0, 1'b0, 8'hFE, 3'd4, 1'b0);
        add(vecs_b, 3'b010, 8'h00, 1'b1, 1'b0, 8'hFF, 3'd5, 1'b0);
        add(vecs_b, 3'b011, 8'h00, 1'b0, 1'b0, 8'hFE, 3'd6, 1'b0);
        add(vecs_b, 3'b100, 8'h00, 1'b0, 1'b0, 8'h7F, 3'd7, 1'b0);
        add(vecs_b, 3'b001, 8'h3C, 1'b0, 1'b0, 8'h3C, 3'd0, 1'b0);
        add(vecs_b, 3'b010, 8'h00, 1'b0, 1'b0, 8'h1E, 3'd1, 1'b0);

        reset_n = 1'b0;
        mode8 = 3'b000; din8 = '0; sr8 = 1'b0; sl8 = 1'b0;
        mode5 = 3'b000; din5 = '0; sr5 = 1'b0; sl5 = 1'b0;

        #12;
        check8("reset", 8'h00, 3'd0, 1'b0);
        check("reset5.data", 64'(dout5), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // asynchronous reset mid-operation, observed before the next rising edge
        drive8(3'b001, 8'hA5, 1'b0, 1'b0);
        drive8(3'b010, 8'h00, 1'b1, 1'b0);
        check8("pre_rst", 8'hD2, 3'd1, 1'b0);
        drive8(3'b001, 8'hA5, 1'b0, 1'b0);
        check8("pre_rst2", 8'hA5, 3'd0, 1'b0);
        @(negedge clk);
        mode8 = 3'b010;
        #2;
        reset_n = 1'b0;
        #1;
        check8("async_rst", 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        mode8 = 3'b000;

        run_table(vecs_a, "tab_a");

        // 16 back-to-back SHL with serial_in_l=1: frame_done every 8th cycle, no gap
        exp8 = 8'h4D;
        c = 0;
        for (int i = 0; i < 16; i++) begin
            drive8(3'b011, 8'h00, 1'b0, 1'b1);
            exp8 = {exp8[W8-2:0], 1'b1};
            c = (c + 1) % W8;
            check8($sformatf("shl16[%0d]", i), exp8, 3'(c), (c == 0));
        end
        check("shl16.final", 64'(dout8), 64'hFF);

        run_table(vecs_b, "tab_b");

        // WIDTH=5 frame wrap
        drive5(3'b110, 1'b0);
        check("w5.clr.data", 64'(dout5), 64'd0);
        check("w5.clr.cnt", 64'(cnt5), 64'd0);
        exp5 = '0;
        c = 0;
        for (int i = 0; i < 12; i++) begin
            drive5(3'b010, 1'b1);
            exp5 = {1'b1, exp5[W5-1:1]};
            c = (c + 1) % W5;
            check($sformatf("w5[%0d].data", i), 64'(dout5), 64'(exp5));
            check($sformatf("w5[%0d].cnt", i), 64'(cnt5), 64'(c));
            check($sformatf("w5[%0d].done", i), 64'(done5), 64'(c == 0));
            check($sformatf("w5[%0d].cnt_max", i), 64'(cnt5 <= 3'd4), 64'd1);
            check($sformatf("w5[%0d].sor", i), 64'(sor5), 64'(exp5[0]));
        end
        drive5(3'b111, 1'b0);
        check("w5.rsvd.cnt", 64'(cnt5), 64'd2);
        check("w5.rsvd.done", 64'(done5), 64'd0);
        check("w5.rsvd.sol", 64'(sol5), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
